rw_window_reducer: RTL and testbench
====================================

// Module: rw_window_reducer
// PURPOSE
//  Parametrised, multi-channel successor to the single-bit toggle/AND resumption machine.
//  Accepts CHANNELS lanes of WIDTH-bit samples over a valid/ready stream.
//  Reduces each lane bitwise over a window of WINDOW samples (AND/OR/XOR/LAST), then emits one frame.
//  Keeps the continue/halt semantics of generated top levels: cont drops permanently once halted.
// PARAMETERS
//  WIDTH     1   bits per lane
//  CHANNELS  4   independent lanes; in_data/out_data are CHANNELS*WIDTH wide, lane k at [k*WIDTH +: WIDTH]
//  WINDOW    4   samples reduced per frame; legal range 2..256
//  FRAME_W   8   width of the emitted-frame counter; wraps modulo 2**FRAME_W
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 reset, asynchronous, active-high
//  mode       in   2                 00 AND, 01 OR, 10 XOR, 11 LAST (decimate); sampled at frame start
//  halt       in   1                 request stop at next frame boundary; level, sampled every cycle
//  in_valid   in   1                 input sample valid
//  in_ready   out  1                 block can accept a sample
//  in_data    in   CHANNELS*WIDTH    input sample, all lanes
//  out_valid  out  1                 reduced frame valid
//  out_ready  in   1                 downstream accepts frame
//  out_data   out  CHANNELS*WIDTH    reduced frame, registered
//  out_frame  out  FRAME_W           index of frame on out_data
//  cont       out  1                 1 while running; 0 once HALTED
// BEHAVIOUR
//  - Reset (async, while rst=1):
//    - state=ACCUM, cnt=0, acc=0, out_data=0, out_frame=0, out_valid=0.
//    - cont=1, halt_pend=0, in_ready=0 while rst is high.
//  - States:
//    - ACCUM: in_ready=1, out_valid=0.
//    - EMIT: in_ready=0, out_valid=1.
//    - HALTED: in_ready=0, out_valid=0, cont=0. Terminal; only rst leaves it.
//  - Accept: a sample is taken on a cycle with in_valid&in_ready. cnt is $clog2(WINDOW) bits.
//  - ACCUM, accept with cnt==0:
//    - mode latched into mode_q; acc=in_data; cnt=1.
//    - A mode change on any later cycle of the frame is ignored.
//  - ACCUM, accept with 0<cnt<WINDOW-1: acc=op(acc,in_data) per lane, bitwise; cnt++.
//  - ACCUM, accept with cnt==WINDOW-1:
//    - out_data=op(acc,in_data); cnt=0; acc=0; next state EMIT.
//    - Frame latency: out_valid rises 1 cycle after the WINDOW-th accept.
//  - op by mode_q: AND a&b; OR a|b; XOR a^b; LAST b.
//  - EMIT: out_data and out_frame are held stable until out_valid&out_ready. On that cycle:
//    - out_frame++ (wraps 2**FRAME_W-1 -> 0).
//    - next state = halt_pend ? HALTED : ACCUM.
//  - One bubble cycle between frames: no sample is accepted in the handshake cycle.
//  - halt_pend: set on any cycle halt=1 in ACCUM or EMIT; cleared only by rst.
//    - ACCUM with cnt==0 and halt=1: go to HALTED next cycle. A sample offered that cycle is not accepted (in_ready is forced 0 when halt=1 and cnt==0).
//    - ACCUM mid-frame: the frame completes, is emitted, then the block halts.
//  - No backpressure loss: while in EMIT, in_valid is ignored and upstream must hold.
//  - rst mid-frame: the partial window is discarded; no frame is emitted.
// STRUCTURE
//  - Package rw_window_reducer_pkg:
//    - mode_t enum {MODE_AND, MODE_OR, MODE_XOR, MODE_LAST}.
//    - state_t enum {ST_ACCUM, ST_EMIT, ST_HALTED}.
//    - function lane_op(mode_t, a, b).
//  - Sub-module rw_lane_reduce (WIDTH): combinational lane_op per lane, instantiated CHANNELS times by generate.
//  - Top holds the FSM, counters, acc/out registers and the halt_pend flag.
// TESTING
//  1. WIDTH=1, CHANNELS=4, AND: samples F,F,7,F, out_ready=1 -> out_data=4'h7, out_frame=0, out_valid 1 cycle after 4th accept.
//  2. XOR mode, samples 1,2,4,8 -> out_data=4'hF. Mode switched to OR after sample 2 -> out_data still 4'hF (XOR kept).
//  3. out_ready=0 for 5 cycles in EMIT -> out_data and out_frame stable, in_ready=0. Release -> frame counter advances by exactly 1.
//  4. FRAME_W=2, emit 5 frames -> out_frame sequence 0,1,2,3,0.
//  5. halt pulse during sample 2 of a frame -> that frame emitted, then cont=0 and in_ready=0 forever. halt with cnt==0 -> HALTED next cycle, no frame emitted.
//  6. rst asserted after 3 of 4 samples -> out_valid=0, out_frame=0, cont=1. The next 4 samples yield a fresh frame equal to their reduction.

Source files
------------

// File: rtl/rw_window_reducer_pkg.sv
// Shared types and the per-bit reduction operator for the window reducer.
package rw_window_reducer_pkg;

  typedef enum logic [1:0] {MODE_AND, MODE_OR, MODE_XOR, MODE_LAST} mode_t;
  typedef enum logic [1:0] {ST_ACCUM, ST_EMIT, ST_HALTED} state_t;

  // LAST keeps the newest bit, which turns the reducer into a decimator.
  function automatic logic lane_op(mode_t m, logic a, logic b);
    case (m)
      MODE_AND: return a & b;
      MODE_OR:  return a | b;
      MODE_XOR: return a ^ b;
      default:  return b;
    endcase
  endfunction

endpackage

// File: rtl/rw_window_reducer_if.sv
// Sample-in / frame-out stream bundle plus the halt/continue control pair.
interface rw_window_reducer_if
  import rw_window_reducer_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int FRAME_W  = 8
);
  mode_t                        mode;
  logic                         halt;
  logic                         in_valid;
  logic                         in_ready;
  logic [CHANNELS*WIDTH-1:0]    in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [CHANNELS*WIDTH-1:0]    out_data;
  logic [FRAME_W-1:0]           out_frame;
  logic                         cont;

  modport master (
    output mode, halt, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_frame, cont
  );

  modport slave (
    input  mode, halt, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_frame, cont
  );
endinterface

// File: rtl/rw_window_reducer_lane.sv
// One lane of the reducer: bitwise lane_op over a WIDTH-bit sample.
module rw_lane_reduce
  import rw_window_reducer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    assign y[i] = lane_op(mode, a[i], b[i]);
  end

endmodule

// File: rtl/rw_window_reducer.sv
// Multi-lane window reducer: folds WINDOW samples per lane into one frame,
// with a sticky halt that stops the block at the next frame boundary.
module rw_window_reducer
  import rw_window_reducer_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int WINDOW   = 4,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  rw_window_reducer_if.slave bus
);

  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

  state_t                            state;
  mode_t                             modeQ;
  logic [CW-1:0]                     cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]    acc;
  logic [CHANNELS-1:0][WIDTH-1:0]    inLanes;
  logic [CHANNELS-1:0][WIDTH-1:0]    opRes;
  logic [CHANNELS-1:0][WIDTH-1:0]    outData;
  logic [FRAME_W-1:0]                outFrame;
  logic                              haltPend;
  logic                              haltNow;
  logic                              atStart;
  logic                              accept;

  assign inLanes = bus.in_data;
  assign haltNow = bus.halt | haltPend;
  assign atStart = (cnt == '0);

  // A halt seen at a frame boundary must not swallow the sample offered alongside it.
  assign bus.in_ready  = !rst && (state == ST_ACCUM) && !(haltNow && atStart);
  assign bus.out_valid = (state == ST_EMIT);
  assign bus.cont      = (state != ST_HALTED);
  assign bus.out_data  = outData;
  assign bus.out_frame = outFrame;
  assign accept        = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : gLane
    rw_lane_reduce #(.WIDTH(WIDTH)) uLane (
      .mode (modeQ),
      .a    (acc[k]),
      .b    (inLanes[k]),
      .y    (opRes[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ACCUM;
      modeQ    <= MODE_AND;
      cnt      <= '0;
      acc      <= '0;
      outData  <= '0;
      outFrame <= '0;
      haltPend <= 1'b0;
    end else begin
      if (state != ST_HALTED && bus.halt) haltPend <= 1'b1;
      case (state)
        ST_ACCUM: begin
          if (haltNow && atStart) begin
            state <= ST_HALTED;
          end else if (accept) begin
            if (atStart) begin
              // Mode is frozen for the whole window from its first sample.
              modeQ <= bus.mode;
              acc   <= inLanes;
              cnt   <= CW'(1);
            end else if (cnt == CNT_LAST) begin
              outData <= opRes;
              acc     <= '0;
              cnt     <= '0;
              state   <= ST_EMIT;
            end else begin
              acc <= opRes;
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            outFrame <= outFrame + FRAME_W'(1);
            state    <= haltNow ? ST_HALTED : ST_ACCUM;
          end
        end
        default: state <= ST_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_window_reducer.sv
// Directed bench for rw_window_reducer: 4 lanes x 1 bit, window 4, 2-bit frame counter.
module tb_rw_window_reducer;
  import rw_window_reducer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;

  always #5 clk = ~clk;

  rw_window_reducer_if #(.WIDTH(1), .CHANNELS(4), .FRAME_W(2)) bus ();

  rw_window_reducer #(.WIDTH(1), .CHANNELS(4), .WINDOW(4), .FRAME_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Offer one sample and return #1 after the edge that accepted it.
  task automatic push(input logic [3:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("push_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expectFrame(input string tag, input logic [3:0] d, input logic [1:0] f);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"},   32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  32'(bus.out_data),  32'(d));
    check({tag, "_frame"}, 32'(bus.out_frame), 32'(f));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_done"},  32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode      = MODE_AND;
    bus.halt      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_cont",      32'(bus.cont),      32'd1);
    check("rst_frame",     32'(bus.out_frame), 32'd0);
    check("rst_data",      32'(bus.out_data),  32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // AND window, frame latency
    bus.mode = MODE_AND;
    push(4'hF); push(4'hF); push(4'h7);
    check("t1_pre_vld", 32'(bus.out_valid), 32'd0);
    push(4'hF);
    check("t1_lat_vld", 32'(bus.out_valid), 32'd1);
    expectFrame("t1", 4'h7, 2'd0);

    // reset mid-frame discards the partial window and the frame index
    bus.mode = MODE_OR;
    push(4'h1); push(4'h2); push(4'h4);
    rst = 1'b1;
    #2;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_frame",     32'(bus.out_frame), 32'd0);
    check("t6_cont",      32'(bus.cont),      32'd1);
    check("t6_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    bus.mode = MODE_XOR;
    push(4'h1); push(4'h2); push(4'h4); push(4'h1);
    expectFrame("t6_fresh", 4'h6, 2'd0);

    // XOR, mode changes mid-frame ignored, OR, LAST, frame wrap
    bus.mode = MODE_XOR;
    push(4'h1); push(4'h2); push(4'h4); push(4'h8);
    expectFrame("t2_xor", 4'hF, 2'd1);
    push(4'h1); push(4'h2);
    bus.mode = MODE_OR;
    push(4'h4); push(4'h8);
    expectFrame("t2_keep", 4'hF, 2'd2);
    bus.mode = MODE_XOR;
    push(4'h3); push(4'h3);
    bus.mode = MODE_OR;
    push(4'h5); push(4'h5);
    expectFrame("t2_keep2", 4'h0, 2'd3);
    bus.mode = MODE_OR;
    push(4'h1); push(4'h0); push(4'h0); push(4'h2);
    expectFrame("t4_wrap_or", 4'h3, 2'd0);
    bus.mode = MODE_LAST;
    push(4'h1); push(4'h2); push(4'h3); push(4'h9);
    expectFrame("t2_last", 4'h9, 2'd1);

    // backpressure in EMIT
    bus.mode      = MODE_AND;
    bus.out_ready = 1'b0;
    push(4'hA); push(4'hE); push(4'hB); push(4'hF);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_vld",   32'(bus.out_valid), 32'd1);
      check("t3_hold_data",  32'(bus.out_data),  32'hA);
      check("t3_hold_frame", 32'(bus.out_frame), 32'd2);
      check("t3_hold_rdy",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t3_frame_step", 32'(bus.out_frame), 32'd3);
    check("t3_vld_drop",   32'(bus.out_valid), 32'd0);
    push(4'hF); push(4'hF); push(4'hF); push(4'hF);
    expectFrame("t3_no_leak", 4'hF, 2'd3);

    // halt mid-frame: frame finishes, then terminal stop
    bus.mode = MODE_OR;
    push(4'h1);
    bus.halt = 1'b1;
    push(4'h2);
    bus.halt = 1'b0;
    push(4'h0); push(4'h8);
    check("t5_cont_emit", 32'(bus.cont), 32'd1);
    expectFrame("t5_last", 4'hB, 2'd0);
    check("t5_cont", 32'(bus.cont), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_halt_rdy",  32'(bus.in_ready),  32'd0);
      check("t5_halt_vld",  32'(bus.out_valid), 32'd0);
      check("t5_halt_cont", 32'(bus.cont),      32'd0);
    end
    bus.in_valid = 1'b0;

    // halt at a frame boundary: no accept, stop next cycle
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5b_cont_rst", 32'(bus.cont), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    bus.halt     = 1'b1;
    #1;
    check("t5b_rdy_forced", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.halt     = 1'b0;
    check("t5b_cont", 32'(bus.cont),     32'd0);
    check("t5b_rdy",  32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5b_no_frame", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
